// File: rtl/axis_packet_arbiter_if.sv
// Axis_If: a minimal AXI-Stream style channel carrying valid/ready/data/last.
//   Master modport drives valid/data/last and observes ready.
//   Slave modport observes valid/data/last and drives ready.
interface Axis_If #(
    parameter int DWIDTH = 256
);
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;
    logic              last;

    modport Master (output valid, output data, output last, input ready);
    modport Slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-atomic round-robin arbiter that merges
// N_INPUTS AXI-Stream requesters onto one registered output stream.
//
// Ports:
//   clk           - single clock for all logic
//   reset         - asynchronous, active-high reset
//   data_in[]     - requester streams (Slave side: valid/data/last in, ready out)
//   data_out      - shared output stream (Master side), 1-cycle registered
//   enable        - permits new grants; an ongoing packet always completes
//   active_source - index of the currently / most recently granted input
//   busy          - high while a grant is held
module axis_packet_arbiter #(
    parameter int N_INPUTS = 4,
    parameter int DWIDTH   = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    Axis_If.Slave                       data_in [N_INPUTS],
    Axis_If.Master                      data_out,
    input  logic                        enable,
    output logic [$clog2(N_INPUTS)-1:0] active_source,
    output logic                        busy
);
    localparam int IW = $clog2(N_INPUTS);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t              state;
    logic [IW-1:0]       g;
    logic [IW-1:0]       p;

    logic [N_INPUTS-1:0] in_valid;
    logic [N_INPUTS-1:0] in_last;
    logic [N_INPUTS-1:0] in_ready;
    logic [DWIDTH-1:0]   in_data [N_INPUTS];

    logic                out_valid;
    logic                out_last;
    logic [DWIDTH-1:0]   out_data;

    logic                grant_ready;
    logic                beat_accept;
    logic                any_valid;
    logic [IW-1:0]       pick;
    logic [IW:0]         search_idx;

    // Interface arrays cannot be indexed by a run-time value, so flatten them.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
        assign in_valid[i]       = data_in[i].valid;
        assign in_last[i]        = data_in[i].last;
        assign in_data[i]        = data_in[i].data;
        assign data_in[i].ready  = in_ready[i];
    end

    // The granted input may push a beat whenever the output register is
    // empty or being drained this cycle.
    assign grant_ready = (state == GRANTED) && (data_out.ready || !out_valid);
    assign beat_accept = grant_ready && in_valid[g];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            in_ready[i] = grant_ready && (g == IW'(i));
        end
    end

    // Round-robin search starting at p. The index is one bit wider than g so
    // p+k never overflows, and the modulo is a single conditional subtract,
    // which keeps the wrap correct for non-power-of-two N_INPUTS.
    always_comb begin
        any_valid  = 1'b0;
        pick       = p;
        search_idx = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            search_idx = {1'b0, p} + (IW+1)'(k);
            if (search_idx >= (IW+1)'(N_INPUTS)) begin
                search_idx = search_idx - (IW+1)'(N_INPUTS);
            end
            if (!any_valid && in_valid[search_idx[IW-1:0]]) begin
                any_valid = 1'b1;
                pick      = search_idx[IW-1:0];
            end
        end
    end

    // Grant FSM plus the output register. A grant is only released by an
    // accepted beat carrying last, so enable or other valids cannot cut a
    // packet short.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            g         <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && any_valid) begin
                        g     <= pick;
                        state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (beat_accept && in_last[g]) begin
                        state <= IDLE;
                        p     <= (g == IW'(N_INPUTS-1)) ? '0 : g + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (beat_accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[g];
                out_last  <= in_last[g];
            end else if (data_out.ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign data_out.valid = out_valid;
    assign data_out.data  = out_data;
    assign data_out.last  = out_last;
    assign busy           = (state == GRANTED);
    assign active_source  = g;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: randomized directed bench for axis_packet_arbiter.
// A 4-input instance is checked every cycle against a transaction-level
// reference model (packet queues per source, round-robin pointer as an int);
// a 3-input instance checks pointer wrap for a non-power-of-two size.
module tb_axis_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          out_ready;
    logic [N-1:0]  s_val;
    logic [N-1:0]  s_last;
    logic [DW-1:0] s_data [N];
    logic [N-1:0]  s_rdy;
    logic [1:0]    active_source;
    logic          busy;

    logic          enable3;
    logic [2:0]    v3;
    logic [2:0]    r3;
    logic [1:0]    act3;
    logic          busy3;

    Axis_If #(.DWIDTH(DW)) src [N] ();
    Axis_If #(.DWIDTH(DW)) sink ();
    Axis_If #(.DWIDTH(8))  src3 [3] ();
    Axis_If #(.DWIDTH(8))  sink3 ();

    for (genvar i = 0; i < N; i++) begin : g_src
        assign src[i].valid = s_val[i];
        assign src[i].data  = s_data[i];
        assign src[i].last  = s_last[i];
        assign s_rdy[i]     = src[i].ready;
    end
    assign sink.ready = out_ready;

    for (genvar i = 0; i < 3; i++) begin : g_src3
        assign src3[i].valid = v3[i];
        assign src3[i].data  = 8'(i);
        assign src3[i].last  = 1'b1;
        assign r3[i]         = src3[i].ready;
    end
    assign sink3.ready = 1'b1;

    axis_packet_arbiter #(.N_INPUTS(N), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .data_in(src), .data_out(sink),
        .enable(enable), .active_source(active_source), .busy(busy)
    );

    axis_packet_arbiter #(.N_INPUTS(3), .DWIDTH(8)) dut3 (
        .clk(clk), .reset(reset), .data_in(src3), .data_out(sink3),
        .enable(enable3), .active_source(act3), .busy(busy3)
    );

    always #5 clk = ~clk;

    // Reference model state
    beat_t         src_q [N][$];
    beat_t         exp_by_src [N][$];
    beat_t         out_log [$];
    beat_t         exp_log [$];
    logic [N-1:0]  src_mute;
    bit            rand_ready;
    bit            m_granted;
    int            m_owner;
    int            m_ptr;
    bit            m_out_valid;
    logic [DW-1:0] m_out_data;
    bit            m_out_last;
    int            cycle_count;
    int            first_out;
    int            checks   = 0;
    int            failures = 0;

    task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_granted   = 1'b0;
        m_owner     = 0;
        m_ptr       = 0;
        m_out_valid = 1'b0;
        m_out_data  = '0;
        m_out_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            exp_by_src[i].delete();
        end
        out_log.delete();
        exp_log.delete();
        src_mute   = '0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic driveSources();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_val[i]  = !src_mute[i];
                s_data[i] = src_q[i][0].data;
                s_last[i] = src_q[i][0].last;
            end else begin
                s_val[i]  = 1'b0;
                s_data[i] = '0;
                s_last[i] = 1'b0;
            end
        end
    endtask

    task automatic addBeat(int s, logic [DW-1:0] d, logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[s].push_back(b);
        exp_by_src[s].push_back(b);
    endtask

    task automatic addPacket(int s, int len);
        for (int b = 0; b < len; b++) begin
            addBeat(s, {4'(s), 4'(b), 8'($urandom)}, (b == len - 1));
        end
    endtask

    // The next whole packet of source s is expected next on the output.
    task automatic expectPacket(int s);
        beat_t b;
        do begin
            b = exp_by_src[s].pop_front();
            exp_log.push_back(b);
        end while (!b.last && exp_by_src[s].size() > 0);
    endtask

    task automatic compareLog(string tag);
        checkOutput($sformatf("%s:beats", tag), 64'(out_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < out_log.size() && i < exp_log.size(); i++) begin
            checkOutput($sformatf("%s:beat%0d", tag, i), 64'(out_log[i]), 64'(exp_log[i]));
        end
    endtask

    task automatic applyReset(string tag);
        reset = 1'b1;
        #1;
        checkOutput($sformatf("%s:rst_busy", tag), 64'(busy), 64'(0));
        checkOutput($sformatf("%s:rst_active", tag), 64'(active_source), 64'(0));
        checkOutput($sformatf("%s:rst_valid", tag), 64'(sink.valid), 64'(0));
        checkOutput($sformatf("%s:rst_data", tag), 64'(sink.data), 64'(0));
        checkOutput($sformatf("%s:rst_last", tag), 64'(sink.last), 64'(0));
        checkOutput($sformatf("%s:rst_ready", tag), 64'(s_rdy), 64'(0));
        checkOutput($sformatf("%s:rst_busy3", tag), 64'(busy3), 64'(0));
        modelReset();
        driveSources();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic stepCycle(string tag);
        int    pick;
        int    c;
        bit    accept;
        beat_t b;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        driveSources();
        #1;
        checkOutput($sformatf("%s:busy", tag), 64'(busy), 64'(m_granted));
        checkOutput($sformatf("%s:active", tag), 64'(active_source), 64'(m_owner));
        checkOutput($sformatf("%s:out_valid", tag), 64'(sink.valid), 64'(m_out_valid));
        checkOutput($sformatf("%s:out_data", tag), 64'(sink.data), 64'(m_out_data));
        checkOutput($sformatf("%s:out_last", tag), 64'(sink.last), 64'(m_out_last));
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("%s:ready%0d", tag, i), 64'(s_rdy[i]),
                        64'(m_granted && i == m_owner && (out_ready || !m_out_valid)));
        end
        if (sink.valid === 1'b1 && first_out < 0) first_out = cycle_count;
        if (sink.valid === 1'b1 && out_ready) begin
            b.data = sink.data;
            b.last = sink.last;
            out_log.push_back(b);
        end

        accept = m_granted && s_val[m_owner] && (out_ready || !m_out_valid);
        if (!m_granted) begin
            if (enable && s_val != '0) begin
                pick = -1;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (pick < 0 && s_val[c]) pick = c;
                end
                m_owner   = pick;
                m_granted = 1'b1;
            end
        end else if (accept && src_q[m_owner][0].last) begin
            m_granted = 1'b0;
            m_ptr     = (m_owner + 1) % N;
        end
        if (accept) begin
            b           = src_q[m_owner].pop_front();
            m_out_valid = 1'b1;
            m_out_data  = b.data;
            m_out_last  = b.last;
        end else if (out_ready) begin
            m_out_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cycle_count++;
    endtask

    task automatic applyStimulus(string tag, int want_beats, int max_cycles);
        int n = 0;
        while (out_log.size() < want_beats && n < max_cycles) begin
            stepCycle(tag);
            n++;
        end
        checkOutput($sformatf("%s:timeout", tag), 64'(out_log.size() >= want_beats), 64'(1));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   busy_seen;
        bit   prev_busy;
        int   g3 [$];
        reset   = 1'b1;
        enable  = 1'b0;
        enable3 = 1'b0;
        v3      = '0;
        s_val   = '0;
        s_last  = '0;
        for (int i = 0; i < N; i++) s_data[i] = '0;
        out_ready = 1'b1;

        // Single source packet, then all four request: order must start at 3
        applyReset("init");
        enable = 1'b1;
        addBeat(2, 16'hA, 1'b0);
        addBeat(2, 16'hB, 1'b0);
        addBeat(2, 16'hC, 1'b1);
        cycle_count = 0;
        first_out   = -1;
        applyStimulus("single", 3, 20);
        checkOutput("single:latency", 64'(first_out), 64'(2));
        for (int i = 0; i < N; i++) addPacket(i, 1);
        applyStimulus("after_single", 7, 40);
        expectPacket(2);
        expectPacket(3);
        expectPacket(0);
        expectPacket(1);
        expectPacket(2);
        compareLog("single");

        // Round robin over inputs 0,1,3 with 2-beat packets
        applyReset("rr");
        enable = 1'b1;
        for (int r = 0; r < 2; r++) begin
            addPacket(0, 2);
            addPacket(1, 2);
            addPacket(3, 2);
        end
        applyStimulus("rr", 12, 80);
        for (int r = 0; r < 2; r++) begin
            expectPacket(0);
            expectPacket(1);
            expectPacket(3);
        end
        compareLog("rr");

        // Random backpressure on a 4-beat packet
        applyReset("bp");
        enable     = 1'b1;
        rand_ready = 1'b1;
        addPacket(1, 4);
        applyStimulus("bp", 4, 200);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        stepCycle("bp_drain");
        stepCycle("bp_drain");
        expectPacket(1);
        compareLog("bp");

        // Enable gating: no grant while disabled; mid-packet drop completes
        applyReset("en");
        enable = 1'b0;
        addPacket(1, 4);
        busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            stepCycle("en_off");
            if (busy !== 1'b0) busy_seen++;
        end
        checkOutput("en:busy_while_off", 64'(busy_seen), 64'(0));
        enable = 1'b1;
        for (int c = 0; c < 3; c++) stepCycle("en_on");
        enable = 1'b0;
        addPacket(2, 2);
        applyStimulus("en_drop", 4, 20);
        for (int c = 0; c < 5; c++) stepCycle("en_hold");
        expectPacket(1);
        compareLog("en");
        checkOutput("en:src2_waiting", 64'(src_q[2].size()), 64'(2));

        // Valid withdrawn before arbitration must not win
        applyReset("drop");
        enable = 1'b0;
        addPacket(0, 1);
        stepCycle("drop_wait");
        stepCycle("drop_wait");
        src_mute[0] = 1'b1;
        addPacket(1, 1);
        enable = 1'b1;
        stepCycle("drop_arb");
        src_mute[0] = 1'b0;
        applyStimulus("drop", 2, 20);
        expectPacket(1);
        expectPacket(0);
        compareLog("drop");

        // Reset in the middle of a 5-beat packet
        applyReset("mid");
        enable = 1'b1;
        addPacket(0, 5);
        for (int c = 0; c < 3; c++) stepCycle("mid_pkt");
        checkOutput("mid:beat2_shown", 64'(sink.valid), 64'(1));
        applyReset("mid_rst");
        enable = 1'b1;
        addPacket(3, 2);
        addPacket(0, 2);
        applyStimulus("mid_after", 4, 30);
        expectPacket(0);
        expectPacket(3);
        compareLog("mid");

        // Three-input instance: pointer wraps from 2 to 0
        applyReset("wrap");
        enable  = 1'b0;
        v3      = 3'b100;
        enable3 = 1'b1;
        prev_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (busy3 && !prev_busy) g3.push_back(int'(act3));
            prev_busy = busy3;
            if (r3[2] && v3 == 3'b100) v3 = 3'b111;
        end
        checkOutput("wrap:grants", 64'(g3.size() >= 4), 64'(1));
        if (g3.size() >= 4) begin
            checkOutput("wrap:g0", 64'(g3[0]), 64'(2));
            checkOutput("wrap:g1", 64'(g3[1]), 64'(0));
            checkOutput("wrap:g2", 64'(g3[2]), 64'(1));
            checkOutput("wrap:g3", 64'(g3[3]), 64'(2));
        end
        enable3 = 1'b0;
        v3      = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
